w_burst_fifo: RTL and testbench

W_BURST_FIFO -- requirements
Module: w_burst_fifo

---
 rtl/w_burst_fifo.sv | 86 ++++++++
 tb/tb_w_burst_fifo.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_burst_fifo.sv
// Show-ahead W-channel FIFO with burst tracking. In packet mode the head is
// held back until a complete burst (WLAST) is stored, or the buffer is full.
module w_burst_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int STRB_WIDTH   = 4,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6,
  parameter int PACKET_MODE  = 0
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [DATA_WIDTH-1:0]      s_WDATA,
  input  logic [STRB_WIDTH-1:0]      s_WSTRB,
  input  logic                       s_WLAST,
  input  logic                       s_WVALID,
  output logic                       s_WREADY,
  output logic [DATA_WIDTH-1:0]      m_WDATA,
  output logic [STRB_WIDTH-1:0]      m_WSTRB,
  output logic                       m_WLAST,
  output logic                       m_WVALID,
  input  logic                       m_WREADY,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     burst_count,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + STRB_WIDTH + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_CNT   = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] ONE      = PW'(1);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] occ;
  logic [PW-1:0] bcnt;
  logic [EW-1:0] head;
  logic          head_ok;
  logic          push;
  logic          pop;

  // Pointers carry one extra wrap bit, so their difference spans 0..DEPTH.
  assign occ  = wr_ptr - rd_ptr;
  assign head = mem[rd_ptr[AW-1:0]];

  always_comb begin
    s_WREADY    = nrst && (occ < FULL_CNT);
    // Full with no complete burst stored must still release, else a burst
    // longer than DEPTH would deadlock.
    head_ok     = (occ != '0) &&
                  ((PACKET_MODE == 0) || (bcnt != '0) || (occ == FULL_CNT));
    m_WVALID    = nrst && head_ok;
    almost_full = nrst && (occ >= AF_CNT);
    push        = s_WVALID && s_WREADY;
    pop         = m_WVALID && m_WREADY;
  end

  assign m_WDATA     = head[EW-1 -: DATA_WIDTH];
  assign m_WSTRB     = head[STRB_WIDTH:1];
  assign m_WLAST     = head[0];
  assign count       = occ;
  assign burst_count = bcnt;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bcnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
      case ({push && s_WLAST, pop && m_WLAST})
        2'b10:   bcnt <= bcnt + ONE;
        2'b01:   bcnt <= bcnt - ONE;
        default: bcnt <= bcnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s_WDATA, s_WSTRB, s_WLAST};
  end

endmodule

// File: tb/tb_w_burst_fifo.sv
// Directed bench for w_burst_fifo: streaming instance plus a packet-mode instance.
module tb_w_burst_fifo;

  logic        clk;
  logic        nrst;

  logic [31:0] d_s_wdata, d_m_wdata, p_s_wdata, p_m_wdata;
  logic [3:0]  d_s_wstrb, d_m_wstrb, p_s_wstrb, p_m_wstrb;
  logic        d_s_wlast, d_s_wvalid, d_s_wready, d_m_wlast, d_m_wvalid, d_m_wready;
  logic        p_s_wlast, p_s_wvalid, p_s_wready, p_m_wlast, p_m_wvalid, p_m_wready;
  logic [3:0]  d_count, d_bcount, p_count, p_bcount;
  logic        d_af, p_af;

  int tests;
  int fails;

  w_burst_fifo u_dut (
    .clk(clk), .nrst(nrst),
    .s_WDATA(d_s_wdata), .s_WSTRB(d_s_wstrb), .s_WLAST(d_s_wlast),
    .s_WVALID(d_s_wvalid), .s_WREADY(d_s_wready),
    .m_WDATA(d_m_wdata), .m_WSTRB(d_m_wstrb), .m_WLAST(d_m_wlast),
    .m_WVALID(d_m_wvalid), .m_WREADY(d_m_wready),
    .count(d_count), .burst_count(d_bcount), .almost_full(d_af)
  );

  w_burst_fifo #(.PACKET_MODE(1)) u_pkt (
    .clk(clk), .nrst(nrst),
    .s_WDATA(p_s_wdata), .s_WSTRB(p_s_wstrb), .s_WLAST(p_s_wlast),
    .s_WVALID(p_s_wvalid), .s_WREADY(p_s_wready),
    .m_WDATA(p_m_wdata), .m_WSTRB(p_m_wstrb), .m_WLAST(p_m_wlast),
    .m_WVALID(p_m_wvalid), .m_WREADY(p_m_wready),
    .count(p_count), .burst_count(p_bcount), .almost_full(p_af)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    step();
    step();
    tests++;
    if (d_s_wready !== 1'b0 || d_m_wvalid !== 1'b0 || d_af !== 1'b0) begin
      fails++;
      $display("FAIL reset_outs: wready=%b wvalid=%b af=%b, required 0 0 0", d_s_wready, d_m_wvalid, d_af);
    end
    tests++;
    if (d_count !== 4'd0 || d_bcount !== 4'd0 || p_count !== 4'd0 || p_m_wvalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_counts: count=%0d bcount=%0d pcount=%0d pvalid=%b, required 0 0 0 0",
               d_count, d_bcount, p_count, p_m_wvalid);
    end
    nrst = 1'b1;
    #1;
    tests++;
    if (d_s_wready !== 1'b1 || p_s_wready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b/%b, required 1/1", d_s_wready, p_s_wready);
    end
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      d_s_wdata  = 32'(16 + i);
      d_s_wstrb  = 4'(i + 1);
      d_s_wlast  = (i == 3 || i == 7);
      d_s_wvalid = 1'b1;
      step();
      tests++;
      if (d_count !== 4'(i + 1) || d_af !== 1'((i + 1) >= 6)) begin
        fails++;
        $display("FAIL fill_count[%0d]: count=%0d af=%b, required %0d %b", i, d_count, d_af, i + 1, (i + 1) >= 6);
      end
    end
    d_s_wvalid = 1'b0;
    tests++;
    if (d_s_wready !== 1'b0 || d_count !== 4'd8 || d_bcount !== 4'd2 || d_af !== 1'b1) begin
      fails++;
      $display("FAIL full_state: wready=%b count=%0d bcount=%0d af=%b, required 0 8 2 1",
               d_s_wready, d_count, d_bcount, d_af);
    end
    d_m_wready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (d_m_wvalid !== 1'b1 || d_m_wdata !== 32'(16 + i) || d_m_wstrb !== 4'(i + 1) ||
          d_m_wlast !== 1'(i == 3 || i == 7)) begin
        fails++;
        $display("FAIL drain_beat[%0d]: valid=%b data=%h strb=%h last=%b, required 1 %h %h %b",
                 i, d_m_wvalid, d_m_wdata, d_m_wstrb, d_m_wlast, 16 + i, i + 1, (i == 3 || i == 7));
      end
      step();
    end
    d_m_wready = 1'b0;
    tests++;
    if (d_count !== 4'd0 || d_m_wvalid !== 1'b0 || d_bcount !== 4'd0) begin
      fails++;
      $display("FAIL drained: count=%0d valid=%b bcount=%0d, required 0 0 0", d_count, d_m_wvalid, d_bcount);
    end
  endtask

  task automatic test_back_to_back();
    d_s_wlast = 1'b0;
    d_s_wstrb = 4'hF;
    d_s_wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_s_wdata = 32'(32 + i);
      step();
    end
    d_m_wready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d_s_wdata = 32'(35 + i);
      tests++;
      if (d_m_wvalid !== 1'b1 || d_m_wdata !== 32'(32 + i)) begin
        fails++;
        $display("FAIL b2b_data[%0d]: valid=%b data=%h, required 1 %h", i, d_m_wvalid, d_m_wdata, 32 + i);
      end
      step();
      tests++;
      if (d_count !== 4'd3) begin
        fails++;
        $display("FAIL b2b_count[%0d]: count=%0d, required 3", i, d_count);
      end
    end
    d_s_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (d_m_wdata !== 32'(52 + i)) begin
        fails++;
        $display("FAIL b2b_tail[%0d]: data=%h, required %h", i, d_m_wdata, 52 + i);
      end
      step();
    end
    d_m_wready = 1'b0;
    tests++;
    if (d_count !== 4'd0) begin
      fails++;
      $display("FAIL b2b_empty: count=%0d, required 0", d_count);
    end
  endtask

  task automatic test_full_pop();
    d_s_wvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d_s_wdata = 32'(64 + i);
      step();
    end
    d_s_wdata = 32'hEE;
    d_m_wready = 1'b1;
    tests++;
    if (d_count !== 4'd8 || d_s_wready !== 1'b0 || d_m_wdata !== 32'h40) begin
      fails++;
      $display("FAIL fullpop_pre: count=%0d wready=%b data=%h, required 8 0 40", d_count, d_s_wready, d_m_wdata);
    end
    step();
    d_s_wvalid = 1'b0;
    tests++;
    if (d_count !== 4'd7) begin
      fails++;
      $display("FAIL fullpop_count: count=%0d, required 7", d_count);
    end
    for (int i = 1; i < 8; i++) begin
      tests++;
      if (d_m_wdata !== 32'(64 + i)) begin
        fails++;
        $display("FAIL fullpop_drain[%0d]: data=%h, required %h", i, d_m_wdata, 64 + i);
      end
      step();
    end
    d_m_wready = 1'b0;
    tests++;
    if (d_count !== 4'd0 || d_m_wvalid !== 1'b0) begin
      fails++;
      $display("FAIL fullpop_empty: count=%0d valid=%b, required 0 0", d_count, d_m_wvalid);
    end
    d_m_wready = 1'b1;
    step();
    tests++;
    if (d_count !== 4'd0) begin
      fails++;
      $display("FAIL empty_pop_ignored: count=%0d, required 0", d_count);
    end
    d_m_wready = 1'b0;
  endtask

  task automatic test_packet();
    p_s_wstrb = 4'hF;
    p_s_wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p_s_wdata = 32'(80 + i);
      p_s_wlast = (i == 3);
      step();
      tests++;
      if (p_m_wvalid !== 1'(i == 3) || p_bcount !== 4'((i == 3) ? 1 : 0)) begin
        fails++;
        $display("FAIL pkt_hold[%0d]: valid=%b bcount=%0d, required %b %0d", i, p_m_wvalid, p_bcount, i == 3, (i == 3) ? 1 : 0);
      end
    end
    p_s_wvalid = 1'b0;
    p_s_wlast = 1'b0;
    p_m_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (p_m_wvalid !== 1'b1 || p_m_wdata !== 32'(80 + i) || p_m_wlast !== 1'(i == 3)) begin
        fails++;
        $display("FAIL pkt_drain[%0d]: valid=%b data=%h last=%b, required 1 %h %b",
                 i, p_m_wvalid, p_m_wdata, p_m_wlast, 80 + i, i == 3);
      end
      step();
    end
    p_m_wready = 1'b0;
    tests++;
    if (p_count !== 4'd0 || p_bcount !== 4'd0) begin
      fails++;
      $display("FAIL pkt_empty: count=%0d bcount=%0d, required 0 0", p_count, p_bcount);
    end
  endtask

  task automatic test_forced_release();
    int out_idx;
    int cycles;
    bit pushed9;
    bit do_push;
    bit do_pop;
    p_s_wlast = 1'b0;
    p_s_wvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p_s_wdata = 32'(96 + i);
      step();
      tests++;
      if (p_m_wvalid !== 1'(i == 7)) begin
        fails++;
        $display("FAIL forced_valid[%0d]: valid=%b, required %b", i, p_m_wvalid, i == 7);
      end
    end
    p_s_wdata = 32'(104);
    p_s_wlast = 1'b1;
    p_m_wready = 1'b1;
    out_idx = 0;
    cycles = 0;
    pushed9 = 1'b0;
    while (out_idx < 9 && cycles < 40) begin
      p_s_wvalid = !pushed9;
      do_push = p_s_wready && !pushed9;
      do_pop = p_m_wvalid;
      if (do_pop) begin
        tests++;
        if (p_m_wdata !== 32'(96 + out_idx) || p_m_wlast !== 1'(out_idx == 8)) begin
          fails++;
          $display("FAIL forced_beat[%0d]: data=%h last=%b, required %h %b",
                   out_idx, p_m_wdata, p_m_wlast, 96 + out_idx, out_idx == 8);
        end
      end
      step();
      if (do_push) pushed9 = 1'b1;
      if (do_pop) out_idx++;
      cycles++;
    end
    p_s_wvalid = 1'b0;
    p_s_wlast = 1'b0;
    p_m_wready = 1'b0;
    tests++;
    if (out_idx !== 9) begin
      fails++;
      $display("FAIL forced_timeout: delivered=%0d, required 9", out_idx);
    end
    tests++;
    if (p_count !== 4'd0 || p_bcount !== 4'd0) begin
      fails++;
      $display("FAIL forced_empty: count=%0d bcount=%0d, required 0 0", p_count, p_bcount);
    end
  endtask

  task automatic test_reset_mid();
    d_s_wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d_s_wdata = 32'(112 + i);
      d_s_wlast = (i == 1);
      step();
    end
    d_s_wvalid = 1'b0;
    d_s_wlast = 1'b0;
    tests++;
    if (d_count !== 4'd5 || d_bcount !== 4'd1) begin
      fails++;
      $display("FAIL mid_pre: count=%0d bcount=%0d, required 5 1", d_count, d_bcount);
    end
    nrst = 1'b0;
    step();
    tests++;
    if (d_count !== 4'd0 || d_bcount !== 4'd0 || d_m_wvalid !== 1'b0 || d_s_wready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: count=%0d bcount=%0d valid=%b wready=%b, required 0 0 0 0",
               d_count, d_bcount, d_m_wvalid, d_s_wready);
    end
    nrst = 1'b1;
    #1;
    tests++;
    if (d_s_wready !== 1'b1 || d_m_wvalid !== 1'b0) begin
      fails++;
      $display("FAIL mid_release: wready=%b valid=%b, required 1 0", d_s_wready, d_m_wvalid);
    end
    step();
    d_s_wdata = 32'h99;
    d_s_wvalid = 1'b1;
    step();
    d_s_wvalid = 1'b0;
    tests++;
    if (d_count !== 4'd1 || d_m_wvalid !== 1'b1 || d_m_wdata !== 32'h99) begin
      fails++;
      $display("FAIL mid_newdata: count=%0d valid=%b data=%h, required 1 1 99", d_count, d_m_wvalid, d_m_wdata);
    end
    d_m_wready = 1'b1;
    step();
    d_m_wready = 1'b0;
    tests++;
    if (d_count !== 4'd0 || d_m_wvalid !== 1'b0) begin
      fails++;
      $display("FAIL mid_no_stale: count=%0d valid=%b, required 0 0", d_count, d_m_wvalid);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    nrst = 1'b0;
    d_s_wdata = '0; d_s_wstrb = '0; d_s_wlast = 1'b0; d_s_wvalid = 1'b0; d_m_wready = 1'b0;
    p_s_wdata = '0; p_s_wstrb = '0; p_s_wlast = 1'b0; p_s_wvalid = 1'b0; p_m_wready = 1'b0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_pop();
    test_packet();
    test_forced_release();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
